// File: rtl/ls_unit_pkg.sv
// Shared definitions for the load/store unit.
// funct3 codes, byte counts, IO region select and FSM states.
package ls_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] BYTE_LEN = 3'd1;
   localparam logic [2:0] HALF_LEN = 3'd2;
   localparam logic [2:0] WORD_LEN = 3'd4;

   localparam logic [1:0] LS_IO_SEL = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_COMMIT,
      S_ISSUE,
      S_BUSY,
      S_SQUASH
   } ls_state_e;

   function automatic logic is_reserved(input logic [2:0] op);
      return (op == 3'b011) || (op[2:1] == 2'b11);
   endfunction

   function automatic logic [2:0] len_of(input logic [2:0] op);
      logic [2:0] len;
      unique case (op[1:0])
         2'b01:   len = HALF_LEN;
         2'b10:   len = WORD_LEN;
         default: len = BYTE_LEN;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ls_extend.sv
// Load data extension: masks stale upper bytes and
// sign- or zero-extends according to funct3.
module ls_extend
   import ls_unit_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   always_comb begin
      data = '0;
      unique case (1'b1)
         (op == F3_LB):  data = {{24{raw[7]}}, raw[7:0]};
         (op == F3_LH):  data = {{16{raw[15]}}, raw[15:0]};
         (op == F3_LW):  data = raw;
         (op == F3_LBU): data = {24'd0, raw[7:0]};
         (op == F3_LHU): data = {16'd0, raw[15:0]};
         default:        data = '0;
      endcase
   end

endmodule

// File: rtl/ls_unit.sv
// Load/store initiator: one op at a time, commit-gated for
// stores and IO loads, single-pulse request, CDB writeback.
module ls_unit
   import ls_unit_pkg::*;
#(
   parameter int         ROB_TAG_W = 4,
   parameter logic [1:0] IO_SEL    = LS_IO_SEL
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_is_store,
   input  logic [2:0]           in_op,
   input  logic [31:0]          in_base,
   input  logic [31:0]          in_imm,
   input  logic [31:0]          in_sdata,
   input  logic [ROB_TAG_W-1:0] in_tag,
   input  logic                 commit_valid,
   input  logic [ROB_TAG_W-1:0] commit_tag,
   input  logic                 flush,
   output logic                 ls_en,
   output logic                 ls_rw,
   output logic [31:0]          ls_addr,
   output logic [2:0]           ls_len,
   output logic [31:0]          ls_sdata,
   input  logic                 ls_done,
   input  logic [31:0]          ld_data,
   output logic                 wb_valid,
   output logic [ROB_TAG_W-1:0] wb_tag,
   output logic [31:0]          wb_data
);

   ls_state_e            state;
   logic [2:0]           op_q;
   logic [ROB_TAG_W-1:0] tag_q;
   logic [31:0]          addr;
   logic [31:0]          ext;
   logic                 io;
   logic                 accept;

   assign addr     = in_base + in_imm;
   assign io       = (addr[17:16] == IO_SEL);
   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid & in_ready;

   ls_extend u_extend (
      .op   (op_q),
      .raw  (ld_data),
      .data (ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= '0;
         tag_q    <= '0;
         ls_en    <= 1'b0;
         ls_rw    <= 1'b0;
         ls_addr  <= '0;
         ls_len   <= '0;
         ls_sdata <= '0;
         wb_valid <= 1'b0;
         wb_tag   <= '0;
         wb_data  <= '0;
      end else begin
         ls_en    <= 1'b0;
         wb_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept && !flush) begin
                  op_q  <= in_op;
                  tag_q <= in_tag;
                  if (is_reserved(in_op)) begin
                     wb_valid <= 1'b1;
                     wb_tag   <= in_tag;
                     wb_data  <= '0;
                  end else begin
                     ls_rw    <= in_is_store;
                     ls_addr  <= addr;
                     ls_len   <= len_of(in_op);
                     ls_sdata <= in_is_store ? in_sdata : '0;
                     if (in_is_store || io) begin
                        state <= S_WAIT_COMMIT;
                     end else begin
                        state <= S_ISSUE;
                        ls_en <= 1'b1;
                     end
                  end
               end
            end
            S_WAIT_COMMIT: begin
               if (flush) begin
                  state <= S_IDLE;
               end else if (commit_valid && commit_tag == tag_q) begin
                  state <= S_ISSUE;
                  ls_en <= 1'b1;
               end
            end
            S_ISSUE: begin
               state <= flush ? S_SQUASH : S_BUSY;
            end
            S_BUSY: begin
               // a flush landing with ls_done still drains cleanly
               if (ls_done) begin
                  state <= S_IDLE;
                  if (!flush) begin
                     wb_valid <= 1'b1;
                     wb_tag   <= tag_q;
                     wb_data  <= ls_rw ? '0 : ext;
                  end
               end else if (flush) begin
                  state <= S_SQUASH;
               end
            end
            S_SQUASH: begin
               if (ls_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
